// File: rtl/ram_burst_reader.sv
// Burst read sequencer for a registered-read RAM: issues one read per cycle,
// absorbs the one-cycle read latency and streams words through a 2-entry buffer.
module ram_burst_reader #(
  parameter int WORDSIZE = 16,
  parameter int ADDRSIZE = 5,
  parameter int NUMADDR  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDRSIZE-1:0] start_addr,
  input  logic [ADDRSIZE:0]   length,
  output logic                busy,
  output logic                done,
  output logic [ADDRSIZE-1:0] ram_read_addr,
  output logic                ram_rd_en,
  output logic                ram_cs,
  input  logic [WORDSIZE-1:0] ram_data_out,
  output logic [WORDSIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t              r_state, w_state_next;
  logic [ADDRSIZE-1:0] r_addr, w_addr_next;
  logic [ADDRSIZE:0]   r_remain, w_remain_next;
  logic                r_inflight, r_inflight_last;
  logic [WORDSIZE-1:0] r_buf_data [2];
  logic                r_buf_last [2];
  logic                r_wr_ptr, r_rd_ptr;
  logic [1:0]          r_count;
  logic                w_pop, w_push, w_issue, w_last_issue;
  logic [2:0]          w_occupancy;

  assign w_pop        = out_valid & out_ready;
  assign w_push       = r_inflight;
  assign w_occupancy  = {1'b0, r_count} + {2'b00, r_inflight};
  // A word leaving this cycle frees a slot for the read issued this cycle.
  assign w_issue      = (r_state == S_ISSUE) && (w_occupancy < (3'd2 + {2'b00, w_pop}));
  assign w_last_issue = w_issue && (r_remain == (ADDRSIZE+1)'(1));

  assign busy          = (r_state != S_IDLE);
  assign ram_cs        = (r_state != S_IDLE);
  assign ram_rd_en     = w_issue;
  assign ram_read_addr = r_addr;
  assign out_valid     = (r_count != 2'd0);
  assign out_data      = r_buf_data[r_rd_ptr];
  assign out_last      = r_buf_last[r_rd_ptr];

  always_comb begin
    w_state_next  = r_state;
    w_addr_next   = r_addr;
    w_remain_next = r_remain;
    done          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_addr_next   = start_addr;
          w_remain_next = length;
          w_state_next  = (length == '0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_issue) begin
          w_addr_next   = (r_addr == ADDRSIZE'(NUMADDR-1)) ? '0 : r_addr + ADDRSIZE'(1);
          w_remain_next = r_remain - (ADDRSIZE+1)'(1);
          if (w_last_issue) w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!r_inflight && (r_count == 2'd0)) begin
          done         = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_remain        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_addr          <= w_addr_next;
      r_remain        <= w_remain_next;
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
    end
  end

  // Returning RAM data is captured into the buffer in the cycle after issue.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        r_buf_data[gi] <= '0;
        r_buf_last[gi] <= 1'b0;
      end else if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_buf_data[gi] <= ram_data_out;
        r_buf_last[gi] <= r_inflight_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a registered-read RAM model (mem[i]=i).
module tb_ram_burst_reader;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [4:0]  start_addr;
  logic [5:0]  length;
  logic        busy, done, ram_rd_en, ram_cs, out_valid, out_last;
  logic [4:0]  ram_read_addr;
  logic [15:0] ram_data_out = '0;
  logic [15:0] out_data;
  logic [15:0] mem [8];

  int errors = 0;
  int checks = 0;

  int data_q[$], last_q[$], cyc_q[$], rd_q[$], rdcyc_q[$], done_q[$];
  bit busy_log[64], valid_log[64], cs_log[64], rden_log[64];

  always #5 clk = ~clk;

  initial for (int i = 0; i < 8; i++) mem[i] = 16'(i);

  always @(posedge clk)
    if (ram_cs && ram_rd_en) ram_data_out <= mem[ram_read_addr[2:0]];

  ram_burst_reader #(.WORDSIZE(16), .ADDRSIZE(5), .NUMADDR(8)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .ram_read_addr(ram_read_addr), .ram_rd_en(ram_rd_en),
    .ram_cs(ram_cs), .ram_data_out(ram_data_out), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle 0 carries start; every cycle inputs are driven just after the edge
  // and outputs are sampled 1ns later.
  task automatic run(input string tag, input int a, input int n, input int stall_lo,
                     input int stall_hi, input int restart_cyc, input int rst_cyc,
                     input int max_cyc);
    data_q.delete(); last_q.delete(); cyc_q.delete();
    rd_q.delete(); rdcyc_q.delete(); done_q.delete();
    for (int c = 0; c < 64; c++) begin
      busy_log[c] = 0; valid_log[c] = 0; cs_log[c] = 0; rden_log[c] = 0;
    end
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      start      = (c == 0) || (c == restart_cyc);
      start_addr = (c == 0) ? 5'(a) : 5'd1;
      length     = (c == 0) ? 6'(n) : 6'd3;
      out_ready  = !(c >= stall_lo && c <= stall_hi);
      rst        = (c == rst_cyc);
      #1;
      busy_log[c] = busy; valid_log[c] = out_valid; cs_log[c] = ram_cs; rden_log[c] = ram_rd_en;
      if (ram_rd_en) begin
        rd_q.push_back(int'(ram_read_addr));
        rdcyc_q.push_back(c);
      end
      if (out_valid && out_ready) begin
        data_q.push_back(int'(out_data));
        last_q.push_back(int'(out_last));
        cyc_q.push_back(c);
        $display("%s: word %0d data=%0d last=%0d cycle=%0d", tag, data_q.size()-1, out_data, out_last, c);
      end
      if (done) done_q.push_back(c);
    end
    start = 1'b0; out_ready = 1'b1; rst = 1'b0;
  endtask

  task automatic check_burst(input string tag, input int a, input int n);
    chk({tag, " word count"}, data_q.size(), n);
    chk({tag, " read count"}, rd_q.size(), n);
    for (int i = 0; i < n && i < data_q.size(); i++) begin
      chk($sformatf("%s data%0d", tag, i), data_q[i], (a + i) % 8);
      chk($sformatf("%s last%0d", tag, i), last_q[i], int'(i == n - 1));
    end
    for (int i = 0; i < n && i < rd_q.size(); i++)
      chk($sformatf("%s addr%0d", tag, i), rd_q[i], (a + i) % 8);
    chk({tag, " done count"}, done_q.size(), 1);
  endtask

  initial begin
    int vcount;
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset rd_en", ram_rd_en, 0);
    chk("reset cs", ram_cs, 0);
    chk("reset addr", ram_read_addr, 0);
    chk("reset valid", out_valid, 0);
    chk("reset data", out_data, 0);
    chk("reset last", out_last, 0);

    run("basic", 2, 4, -1, -1, -1, -1, 12);
    check_burst("basic", 2, 4);
    for (int i = 0; i < 4 && i < cyc_q.size(); i++)
      chk($sformatf("basic word%0d cycle", i), cyc_q[i], 3 + i);
    chk("basic first read cycle", rdcyc_q.size() > 0 ? rdcyc_q[0] : -1, 1);
    chk("basic done cycle", done_q.size() > 0 ? done_q[0] : -1, 7);
    chk("basic busy c0", busy_log[0], 0);
    chk("basic busy c1", busy_log[1], 1);
    chk("basic busy c7", busy_log[7], 1);
    chk("basic busy c8", busy_log[8], 0);
    chk("basic cs c8", cs_log[8], 0);

    run("wrap", 6, 4, -1, -1, -1, -1, 12);
    check_burst("wrap", 6, 4);

    run("backpressure", 0, 8, 4, 7, -1, -1, 22);
    check_burst("backpressure", 0, 8);
    for (int c = 4; c <= 7; c++) begin
      chk($sformatf("stall rd_en c%0d", c), rden_log[c], 0);
      if (c >= 5) chk($sformatf("stall valid c%0d", c), valid_log[c], 1);
    end
    chk("resume rd_en c8", rden_log[8], 1);

    run("zero", 0, 0, -1, -1, -1, -1, 6);
    chk("zero done count", done_q.size(), 1);
    chk("zero done cycle", done_q.size() > 0 ? done_q[0] : -1, 1);
    chk("zero busy c1", busy_log[1], 1);
    chk("zero busy c2", busy_log[2], 0);
    chk("zero reads", rd_q.size(), 0);
    vcount = 0;
    for (int c = 0; c < 6; c++) vcount += int'(valid_log[c]);
    chk("zero valid cycles", vcount, 0);

    run("restart", 2, 4, -1, -1, 2, -1, 16);
    check_burst("restart", 2, 4);
    chk("restart done cycle", done_q.size() > 0 ? done_q[0] : -1, 7);

    run("midreset", 0, 8, -1, -1, -1, 4, 10);
    chk("midreset busy c4", busy_log[4], 1);
    chk("midreset busy c5", busy_log[5], 0);
    chk("midreset valid c5", valid_log[5], 0);
    chk("midreset cs c5", cs_log[5], 0);
    chk("midreset done count", done_q.size(), 0);
    run("after reset", 3, 2, -1, -1, -1, -1, 10);
    check_burst("after reset", 3, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
